// File: rtl/i2c_uart_pkg.sv
// Shared types and defaults for the I2C-slave to UART-TX bridge.
package i2c_uart_pkg;

    typedef enum logic [2:0] {
        I2C_IDLE      = 3'd0,
        I2C_ADDR      = 3'd1,
        I2C_ADDR_ACK  = 3'd2,
        I2C_DATA      = 3'd3,
        I2C_DATA_ACK  = 3'd4,
        I2C_WAIT_STOP = 3'd5
    } i2c_state_e;

    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } uart_state_e;

    localparam logic [6:0] DEFAULT_SLAVE_ADDR   = 7'h47;
    localparam int         DEFAULT_CLKS_PER_BIT = 32'd87;

endpackage

// File: rtl/i2c_uart_bridge_uart_tx.sv
// 8N1 UART transmitter; accepts the next byte in the last stop-bit cycle so frames run back-to-back.
module uart_tx
    import i2c_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       TX
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_e      state_r;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             tx_r;
    logic             bit_end_s;

    // Bit-period end detect and byte-accept handshake
    always_comb begin
        bit_end_s = (baud_cnt_r == CNT_LAST);
        ready     = 1'b0;
        case (state_r)
            U_IDLE:  ready = 1'b1;
            U_STOP:  ready = bit_end_s;
            default: ready = 1'b0;
        endcase
    end

    // Frame sequencer: baud counter, bit shifter and registered TX line
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= U_IDLE;
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
        end else begin
            if ((state_r == U_IDLE) || bit_end_s) begin
                baud_cnt_r <= '0;
            end else begin
                baud_cnt_r <= baud_cnt_r + CNT_W'(1);
            end
            case (state_r)
                U_IDLE: begin
                    if (valid) begin
                        state_r <= U_START;
                        shift_r <= data;
                        tx_r    <= 1'b0;
                    end
                end
                U_START: begin
                    if (bit_end_s) begin
                        state_r   <= U_DATA;
                        bit_idx_r <= 3'd0;
                        tx_r      <= shift_r[0];
                    end
                end
                U_DATA: begin
                    if (bit_end_s) begin
                        if (bit_idx_r == 3'd7) begin
                            state_r <= U_STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                        end
                    end
                end
                U_STOP: begin
                    if (bit_end_s) begin
                        if (valid) begin
                            state_r <= U_START;
                            shift_r <= data;
                            tx_r    <= 1'b0;
                        end else begin
                            state_r <= U_IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= U_IDLE;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

    assign TX = tx_r;

endmodule

// File: rtl/i2c_uart_bridge.sv
// Write-only I2C slave that forwards each accepted data byte to an 8N1 UART transmitter
// through a one-byte holding buffer.
module i2c_uart_bridge
    import i2c_uart_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR   = DEFAULT_SLAVE_ADDR,
    parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic SCL,
    inout  wire  SDA,
    output logic TX
);

    logic [1:0] scl_sync_r;
    logic [1:0] sda_sync_r;
    logic       scl_prev_r;
    logic       sda_prev_r;
    logic       scl_rise_s;
    logic       scl_fall_s;
    logic       start_s;
    logic       stop_s;

    i2c_state_e i2c_state_r;
    logic [2:0] bit_cnt_r;
    logic [6:0] shift_r;
    logic       drive_low_r;
    logic [7:0] byte_s;
    logic       load_s;
    logic       take_s;

    logic [7:0] buf_data_r;
    logic       buf_full_r;
    logic       uart_ready_s;

    // Two-flop synchronizers plus one delayed copy for edge detection; idle bus is high
    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[0], SCL};
            sda_sync_r <= {sda_sync_r[0], SDA};
            scl_prev_r <= scl_sync_r[1];
            sda_prev_r <= sda_sync_r[1];
        end
    end

    // Bus events, assembled byte and buffer handshakes
    always_comb begin
        scl_rise_s = scl_sync_r[1] & ~scl_prev_r;
        scl_fall_s = ~scl_sync_r[1] & scl_prev_r;
        start_s    = scl_sync_r[1] & scl_prev_r & sda_prev_r & ~sda_sync_r[1];
        stop_s     = scl_sync_r[1] & scl_prev_r & ~sda_prev_r & sda_sync_r[1];
        byte_s     = {shift_r, sda_sync_r[1]};
        load_s     = (i2c_state_r == I2C_DATA) & scl_rise_s & (bit_cnt_r == 3'd7) & ~buf_full_r;
        take_s     = buf_full_r & uart_ready_s;
    end

    // I2C slave FSM; drive_low_r doubles as the ACK-phase marker in the ACK states
    always_ff @(posedge clk) begin
        if (!reset) begin
            i2c_state_r <= I2C_IDLE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 7'd0;
            drive_low_r <= 1'b0;
        end else if (start_s) begin
            i2c_state_r <= I2C_ADDR;
            bit_cnt_r   <= 3'd0;
            drive_low_r <= 1'b0;
        end else if (stop_s) begin
            i2c_state_r <= I2C_IDLE;
            drive_low_r <= 1'b0;
        end else begin
            case (i2c_state_r)
                I2C_IDLE: begin
                    i2c_state_r <= I2C_IDLE;
                end
                I2C_ADDR: begin
                    if (scl_rise_s) begin
                        shift_r   <= byte_s[6:0];
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            if ((byte_s[7:1] == SLAVE_ADDR) && !byte_s[0]) begin
                                i2c_state_r <= I2C_ADDR_ACK;
                            end else begin
                                i2c_state_r <= I2C_WAIT_STOP;
                            end
                        end
                    end
                end
                I2C_ADDR_ACK, I2C_DATA_ACK: begin
                    if (scl_fall_s) begin
                        if (!drive_low_r) begin
                            drive_low_r <= 1'b1;
                        end else begin
                            drive_low_r <= 1'b0;
                            i2c_state_r <= I2C_DATA;
                            bit_cnt_r   <= 3'd0;
                        end
                    end
                end
                I2C_DATA: begin
                    if (scl_rise_s) begin
                        shift_r   <= byte_s[6:0];
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            if (buf_full_r) begin
                                i2c_state_r <= I2C_WAIT_STOP;
                            end else begin
                                i2c_state_r <= I2C_DATA_ACK;
                            end
                        end
                    end
                end
                I2C_WAIT_STOP: begin
                    i2c_state_r <= I2C_WAIT_STOP;
                end
                default: begin
                    i2c_state_r <= I2C_IDLE;
                    drive_low_r <= 1'b0;
                end
            endcase
        end
    end

    // Holding buffer: load and take are mutually exclusive since load needs an empty buffer
    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_data_r <= 8'h00;
            buf_full_r <= 1'b0;
        end else if (load_s) begin
            buf_data_r <= byte_s;
            buf_full_r <= 1'b1;
        end else if (take_s) begin
            buf_full_r <= 1'b0;
        end
    end

    assign SDA = drive_low_r ? 1'b0 : 1'bz;

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk  (clk),
        .reset(reset),
        .valid(buf_full_r),
        .data (buf_data_r),
        .ready(uart_ready_s),
        .TX   (TX)
    );

endmodule

// File: tb/tb_i2c_uart_bridge.sv
// Directed bench: bit-banged I2C master, open-drain SDA with pull-up, and a UART frame monitor.
`timescale 1ns/1ps
module tb_i2c_uart_bridge;
    import i2c_uart_pkg::*;

    localparam int CPB = 87;

    logic clk = 1'b0;
    logic reset;
    logic scl;
    logic sda_m_low;
    wire  sda;
    logic tx;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         slave_low_cnt = 0;
    int         tx_low_cnt    = 0;
    int         hp       = 50;
    logic       mon_en   = 1'b0;
    logic [7:0] rx_q[$];
    int         rx_t[$];

    assign sda = sda_m_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #50 clk = ~clk;

    i2c_uart_bridge #(.SLAVE_ADDR(7'h47), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .SCL(scl), .SDA(sda), .TX(tx)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Count cycles where the slave pulls SDA low while the master has released it, and TX-low cycles
    always @(negedge clk) begin
        if (!sda_m_low && sda === 1'b0) slave_low_cnt <= slave_low_cnt + 1;
        if (tx === 1'b0) tx_low_cnt <= tx_low_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m_low = 1'b0; scl = 1'b1; wait_clks(hp);
        sda_m_low = 1'b1; wait_clks(hp);
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clks(hp / 2); sda_m_low = 1'b1;
        wait_clks(hp / 2); scl = 1'b1;
        wait_clks(hp);     sda_m_low = 1'b0;
        wait_clks(hp);
    endtask

    task automatic i2c_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            wait_clks(hp / 2); sda_m_low = ~b[i];
            wait_clks(hp / 2); scl = 1'b1;
            wait_clks(hp);     scl = 1'b0;
        end
        wait_clks(hp / 2); sda_m_low = 1'b0;
        wait_clks(hp / 2); scl = 1'b1;
        wait_clks(hp / 2); ack = sda;
        wait_clks(hp / 2); scl = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            wait_clks(1);
            k++;
        end
        check(tag, rx_q.size(), n);
    endtask

    // UART monitor: samples mid-bit, records each byte and the cycle its start bit was seen
    initial begin : uart_mon
        logic [7:0] b;
        int t0;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                t0 = cyc;
                repeat (CPB / 2) @(negedge clk);
                check("uart_start_bit", tx, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                check("uart_stop_bit", tx, 1);
                rx_q.push_back(b);
                rx_t.push_back(t0);
            end
        end
    end

    initial begin : main
        logic a1, a2;
        int s0, t0, nrx;
        logic [7:0] burst_data [3];
        logic       fast_ack   [3];

        reset = 1'b0; scl = 1'b1; sda_m_low = 1'b0;
        wait_clks(5);
        check("reset_tx", tx, 1);
        check("reset_sda", sda, 1);
        check("reset_state", dut.i2c_state_r, I2C_IDLE);
        reset = 1'b1; mon_en = 1'b1;
        wait_clks(10);

        // Single write of 0x67 to 0x47
        i2c_start(); i2c_byte(8'h8E, a1); i2c_byte(8'h67, a2); i2c_stop();
        check("wr_addr_ack", a1, 0);
        check("wr_data_ack", a2, 0);
        wait_rx("wr_rx_count", 1, 3000);
        check("wr_rx_byte", rx_q[0], 8'h67);
        wait_clks(200);

        // Wrong address 0x5B
        s0 = slave_low_cnt; t0 = tx_low_cnt;
        i2c_start(); i2c_byte(8'hB6, a1); i2c_byte(8'h67, a2); i2c_stop();
        wait_clks(1000);
        check("wa_addr_nack", a1, 1);
        check("wa_data_nack", a2, 1);
        check("wa_sda_never_low", slave_low_cnt - s0, 0);
        check("wa_tx_idle", tx_low_cnt - t0, 0);

        // Read request to the right address
        t0 = tx_low_cnt;
        i2c_start(); i2c_byte(8'h8F, a1);
        check("rd_nack", a1, 1);
        check("rd_wait_stop", dut.i2c_state_r, I2C_WAIT_STOP);
        i2c_stop(); wait_clks(1000);
        check("rd_idle_after_stop", dut.i2c_state_r, I2C_IDLE);
        check("rd_tx_idle", tx_low_cnt - t0, 0);

        // Three-byte burst at 100 kHz: UART drains each byte before the next arrives
        nrx = rx_q.size();
        burst_data[0] = 8'h01; burst_data[1] = 8'h02; burst_data[2] = 8'h03;
        i2c_start(); i2c_byte(8'h8E, a1);
        check("burst_addr_ack", a1, 0);
        for (int k = 0; k < 3; k++) begin
            i2c_byte(burst_data[k], a2);
            check($sformatf("burst_ack%0d", k), a2, 0);
        end
        i2c_stop();
        wait_rx("burst_rx_count", nrx + 3, 3000);
        for (int k = 0; k < 3; k++)
            check($sformatf("burst_rx%0d", k), rx_q[nrx + k], burst_data[k]);
        wait_clks(200);

        // Fast burst (SCL = clk/16): second byte waits in the buffer, third is NACKed
        hp = 8;
        nrx = rx_q.size();
        i2c_start(); i2c_byte(8'h8E, a1);
        check("fast_addr_ack", a1, 0);
        i2c_byte(8'h11, a2); fast_ack[0] = a2;
        i2c_byte(8'h22, a2); fast_ack[1] = a2;
        i2c_byte(8'h33, a2); fast_ack[2] = a2;
        check("fast_ack0", fast_ack[0], 0);
        check("fast_ack1", fast_ack[1], 0);
        check("fast_nack2", fast_ack[2], 1);
        i2c_stop();
        wait_rx("fast_rx_count", nrx + 2, 3000);
        check("fast_rx0", rx_q[nrx], 8'h11);
        check("fast_rx1", rx_q[nrx + 1], 8'h22);
        check("fast_back_to_back", rx_t[nrx + 1] - rx_t[nrx], 10 * CPB);
        wait_clks(1500);
        check("fast_no_third_frame", rx_q.size(), nrx + 2);

        // Reset in the middle of a UART frame
        hp = 50;
        mon_en = 1'b0;
        wait_clks(100);
        t0 = tx_low_cnt;
        i2c_start(); i2c_byte(8'h8E, a1); i2c_byte(8'hA5, a2); i2c_stop();
        wait_clks(50);
        check("mid_frame_active", (tx_low_cnt - t0) != 0, 1);
        reset = 1'b0;
        wait_clks(1);
        check("mid_reset_tx", tx, 1);
        check("mid_reset_state", dut.i2c_state_r, I2C_IDLE);
        wait_clks(4);
        reset = 1'b1;
        t0 = tx_low_cnt;
        wait_clks(1500);
        check("mid_no_residual", tx_low_cnt - t0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
